// File: rtl/hpi_pkg.sv
// Shared types and helpers for the EZ-OTG HPI bus master.
package hpi_pkg;

  // HPI register select as seen on otg_hpi_address.
  typedef enum logic [1:0] {
    HPI_DATA    = 2'd0,
    HPI_MAILBOX = 2'd1,
    HPI_ADDRESS = 2'd2,
    HPI_STATUS  = 2'd3
  } hpi_reg_e;

  // Bus-cycle sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_WR = 3'd1,
    ST_SETUP   = 3'd2,
    ST_STROBE  = 3'd3,
    ST_HOLD    = 3'd4,
    ST_RD_PUSH = 3'd5,
    ST_RECOVER = 3'd6
  } hpi_state_e;

  // Phase-counter width: enough bits to hold the longest timed phase.
  function automatic int phase_cnt_w(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/otg_hpi_phase_timer.sv
// Loadable down-counter shared by the SETUP/STROBE/HOLD/RECOVER phases.
// Loading N-1 on phase entry makes done_o rise on the phase's last cycle.
module otg_hpi_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load on request, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/otg_hpi_master.sv
// Command-driven EZ-OTG HPI bus master: runs bursts of cmd_len+1 accesses
// to one HPI register with parametrised setup/strobe/hold/recover timing.
// Pin registers are loaded from the next state so they line up with state_q.
module otg_hpi_master
  import hpi_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int LEN_W       = 8,
  parameter int SETUP_CYC   = 1,
  parameter int STROBE_CYC  = 3,
  parameter int HOLD_CYC    = 1,
  parameter int RECOVER_CYC = 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [1:0]        cmd_reg,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic [1:0]        otg_hpi_address,
  output logic              otg_hpi_cs_n,
  output logic              otg_hpi_r_n,
  output logic              otg_hpi_w_n,
  output logic [DATA_W-1:0] otg_hpi_data_out,
  output logic              otg_hpi_data_oe,
  input  logic [DATA_W-1:0] otg_hpi_data_in
);

  localparam int PH_W = phase_cnt_w(SETUP_CYC, STROBE_CYC, HOLD_CYC, RECOVER_CYC);

  hpi_state_e        state_q, state_d;
  logic              write_q, write_d;
  hpi_reg_e          reg_q, reg_d;
  logic [LEN_W-1:0]  wcnt_q, wcnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              oe_q, oe_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;
  logic              cs_n_q, cs_n_d;
  logic              r_n_q, r_n_d;
  logic              w_n_q, w_n_d;
  hpi_reg_e          addr_q, addr_d;
  logic              ph_load, ph_done;
  logic [PH_W-1:0]   ph_val;

  otg_hpi_phase_timer #(.W(PH_W)) u_timer (
    .clk_i      (clk_clk),
    .rst_i      (reset_reset),
    .load_i     (ph_load),
    .load_val_i (ph_val),
    .done_o     (ph_done)
  );

  // Next-state logic for the burst sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (cmd_valid) state_d = cmd_write ? ST_WAIT_WR : ST_SETUP;
      ST_WAIT_WR: if (wr_valid) state_d = ST_SETUP;
      ST_SETUP:   if (ph_done) state_d = ST_STROBE;
      ST_STROBE:  if (ph_done) state_d = ST_HOLD;
      ST_HOLD:    if (ph_done) state_d = write_q ? ST_RECOVER : ST_RD_PUSH;
      ST_RD_PUSH: if (rd_ready) state_d = ST_RECOVER;
      ST_RECOVER: begin
        if (ph_done) begin
          if (wcnt_q == '0) state_d = ST_IDLE;
          else              state_d = write_q ? ST_WAIT_WR : ST_SETUP;
        end
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // Reload the phase timer whenever a timed phase is entered.
  always_comb begin
    ph_load = 1'b0;
    ph_val  = '0;
    if (state_d != state_q) begin
      ph_load = 1'b1;
      case (state_d)
        ST_SETUP:   ph_val = PH_W'(SETUP_CYC - 1);
        ST_STROBE:  ph_val = PH_W'(STROBE_CYC - 1);
        ST_HOLD:    ph_val = PH_W'(HOLD_CYC - 1);
        ST_RECOVER: ph_val = PH_W'(RECOVER_CYC - 1);
        default:    ph_load = 1'b0;
      endcase
    end
  end

  // Command latch, word counter, data registers and pin next-values.
  always_comb begin
    write_d = write_q;
    reg_d   = reg_q;
    wcnt_d  = wcnt_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    rdat_d  = rdat_q;
    addr_d  = addr_q;
    if (state_q == ST_IDLE && cmd_valid) begin
      write_d = cmd_write;
      reg_d   = hpi_reg_e'(cmd_reg);
      wcnt_d  = cmd_len;
    end
    if (state_q == ST_WAIT_WR && wr_valid) begin
      dout_d = wr_data;
      oe_d   = 1'b1;
    end
    // The last STROBE cycle is the read sample point.
    if (state_q == ST_STROBE && ph_done && !write_q) begin
      rdat_d = otg_hpi_data_in;
    end
    if (state_d == ST_RECOVER) begin
      oe_d = 1'b0;
    end
    // Decrement only when another word follows, so the counter never wraps.
    if (state_q == ST_RECOVER && ph_done && wcnt_q != '0) begin
      wcnt_d = wcnt_q - 1'b1;
    end
    if (state_d == ST_SETUP) begin
      addr_d = reg_d;
    end
    cs_n_d = !(state_d == ST_SETUP || state_d == ST_STROBE || state_d == ST_HOLD);
    r_n_d  = !(state_d == ST_STROBE && !write_q);
    w_n_d  = !(state_d == ST_STROBE && write_q);
  end

  // State, command and pin registers.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      reg_q   <= HPI_DATA;
      wcnt_q  <= '0;
      dout_q  <= '0;
      oe_q    <= 1'b0;
      rdat_q  <= '0;
      cs_n_q  <= 1'b1;
      r_n_q   <= 1'b1;
      w_n_q   <= 1'b1;
      addr_q  <= HPI_DATA;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      reg_q   <= reg_d;
      wcnt_q  <= wcnt_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      rdat_q  <= rdat_d;
      cs_n_q  <= cs_n_d;
      r_n_q   <= r_n_d;
      w_n_q   <= w_n_d;
      addr_q  <= addr_d;
    end
  end

  assign cmd_ready        = (state_q == ST_IDLE) && !reset_reset;
  assign wr_ready         = (state_q == ST_WAIT_WR);
  assign rd_valid         = (state_q == ST_RD_PUSH);
  assign busy             = (state_q != ST_IDLE);
  assign rd_data          = rdat_q;
  assign otg_hpi_address  = addr_q;
  assign otg_hpi_cs_n     = cs_n_q;
  assign otg_hpi_r_n      = r_n_q;
  assign otg_hpi_w_n      = w_n_q;
  assign otg_hpi_data_out = dout_q;
  assign otg_hpi_data_oe  = oe_q;

endmodule

// File: tb/tb_otg_hpi_master.sv
// Bench for otg_hpi_master: HPI chip model, pin monitors, reference memory.
module tb_otg_hpi_master;
  import hpi_pkg::*;

  localparam int DW = 16;
  localparam int LW = 8;
  localparam int S  = 1, ST = 3, H = 1, R = 2;
  localparam int F_PERIOD = 1 + 1 + 1 + 1 + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, cmd_write;
  logic [1:0]    cmd_reg;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] wr_data, rd_data;
  logic          wr_valid, wr_ready, rd_valid, rd_ready, busy;
  logic [1:0]    hpi_addr;
  logic          cs_n, r_n, w_n, oe;
  logic [DW-1:0] dout, din;

  logic          f_cmd_valid, f_cmd_ready, f_cmd_write;
  logic [1:0]    f_cmd_reg;
  logic [LW-1:0] f_cmd_len;
  logic [DW-1:0] f_wr_data, f_rd_data;
  logic          f_wr_valid, f_wr_ready, f_rd_valid, f_rd_ready, f_busy;
  logic [1:0]    f_addr;
  logic          f_cs_n, f_r_n, f_w_n, f_oe;
  logic [DW-1:0] f_dout;

  otg_hpi_master u_dut (
    .clk_clk(clk), .reset_reset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_reg(cmd_reg), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy),
    .otg_hpi_address(hpi_addr), .otg_hpi_cs_n(cs_n), .otg_hpi_r_n(r_n),
    .otg_hpi_w_n(w_n), .otg_hpi_data_out(dout), .otg_hpi_data_oe(oe),
    .otg_hpi_data_in(din)
  );

  otg_hpi_master #(.STROBE_CYC(1), .RECOVER_CYC(1)) u_fast (
    .clk_clk(clk), .reset_reset(rst),
    .cmd_valid(f_cmd_valid), .cmd_ready(f_cmd_ready), .cmd_write(f_cmd_write),
    .cmd_reg(f_cmd_reg), .cmd_len(f_cmd_len),
    .wr_data(f_wr_data), .wr_valid(f_wr_valid), .wr_ready(f_wr_ready),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .rd_ready(f_rd_ready),
    .busy(f_busy),
    .otg_hpi_address(f_addr), .otg_hpi_cs_n(f_cs_n), .otg_hpi_r_n(f_r_n),
    .otg_hpi_w_n(f_w_n), .otg_hpi_data_out(f_dout), .otg_hpi_data_oe(f_oe),
    .otg_hpi_data_in(16'h0000)
  );

  // HPI chip model: pointer register, auto-increment on DATA, status/mailbox.
  logic [15:0] mem [0:65535];
  logic [15:0] ptr = 16'h0;
  logic [15:0] mailbox = 16'h0;
  logic [15:0] status_val;
  logic [15:0] rd_mux;

  always_comb begin
    case (hpi_addr)
      2'd0:    rd_mux = mem[ptr];
      2'd1:    rd_mux = mailbox;
      2'd2:    rd_mux = ptr;
      default: rd_mux = status_val;
    endcase
  end
  assign din = (!cs_n && !r_n) ? rd_mux : 16'hBEEF;

  int total = 0, bad = 0;
  int cs_low = 0, rn_low = 0, wn_pulses = 0, viol_oe_rn = 0, viol_rd_cs = 0, viol_wr_cs = 0;
  logic wn_prev = 1'b1, rn_prev = 1'b1;
  logic [15:0] rd_q [$];

  // Pin monitor and chip write/auto-increment behaviour.
  always @(posedge clk) begin
    if (rst) begin
      wn_prev <= 1'b1;
      rn_prev <= 1'b1;
    end else begin
      if (!cs_n) cs_low <= cs_low + 1;
      if (!r_n) rn_low <= rn_low + 1;
      if (!w_n && wn_prev) wn_pulses <= wn_pulses + 1;
      if (oe && !r_n) viol_oe_rn <= viol_oe_rn + 1;
      if (rd_valid && !cs_n) viol_rd_cs <= viol_rd_cs + 1;
      if (wr_ready && !cs_n) viol_wr_cs <= viol_wr_cs + 1;
      if (rd_valid && rd_ready) rd_q.push_back(rd_data);
      if (w_n && !wn_prev) begin
        case (hpi_addr)
          2'd0: begin mem[ptr] <= dout; ptr <= ptr + 16'd1; end
          2'd1: mailbox <= dout;
          2'd2: ptr <= dout;
          default: ;
        endcase
      end
      if (r_n && !rn_prev && hpi_addr == 2'd0) ptr <= ptr + 16'd1;
      wn_prev <= w_n;
      rn_prev <= r_n;
    end
  end

  // Monitor for the fast-timing instance: strobe period and write data order.
  logic [15:0] f_exp [0:255];
  int f_cyc = 0, f_last = 0, f_falls = 0, f_period_bad = 0, f_data_bad = 0;
  logic f_wn_prev = 1'b1;
  always @(posedge clk) begin
    if (!rst) begin
      f_cyc <= f_cyc + 1;
      if (!f_w_n && f_wn_prev) begin
        if (f_falls > 0 && (f_cyc - f_last) != F_PERIOD) f_period_bad <= f_period_bad + 1;
        if (f_dout !== f_exp[f_falls % 256]) f_data_bad <= f_data_bad + 1;
        f_last  <= f_cyc;
        f_falls <= f_falls + 1;
      end
      f_wn_prev <= f_w_n;
    end
  end

  // Reference model: expected chip memory and pointer.
  logic [15:0] exp_mem [int];
  int exp_ptr = 0;
  logic [15:0] wq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic w, input logic [1:0] rg, input int len);
    int g;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_reg = rg; cmd_len = len[LW-1:0];
    g = 0;
    while (!cmd_ready && g < 200) begin @(negedge clk); g++; end
    chk("cmd_accept", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input bit rand_rd);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      if (rand_rd) rd_ready = 1'($urandom_range(0, 1));
      g++;
    end while (busy && g < 5000);
    rd_ready = 1'b1;
    chk(tag, busy, 1'b0);
  endtask

  task automatic feed_wr(input bit gap);
    int g;
    for (int i = 0; i < wq.size(); i++) begin
      if (gap && (i % 2 == 1)) repeat (4) @(negedge clk);
      wr_data = wq[i]; wr_valid = 1'b1;
      g = 0;
      do begin @(negedge clk); g++; end while (!wr_ready && g < 200);
      @(posedge clk); #1;
      wr_valid = 1'b0;
    end
  endtask

  task automatic write_burst(input logic [1:0] rg, input bit gap);
    send_cmd(1'b1, rg, wq.size() - 1);
    feed_wr(gap);
    wait_idle("wr_idle", 1'b0);
    foreach (wq[i]) begin
      if (rg == 2'd2) exp_ptr = int'(wq[i]);
      else if (rg == 2'd0) begin exp_mem[exp_ptr] = wq[i]; exp_ptr = (exp_ptr + 1) & 16'hFFFF; end
    end
  endtask

  task automatic set_ptr(input logic [15:0] a);
    wq = '{a};
    write_burst(2'd2, 1'b0);
  endtask

  task automatic check_reads(input int n0, input int n);
    chk("rd_count", rd_q.size() - n0, n);
    for (int i = 0; i < n && (n0 + i) < rd_q.size(); i++) begin
      chk("rd_word", rd_q[n0 + i], exp_mem[exp_ptr]);
      exp_ptr = (exp_ptr + 1) & 16'hFFFF;
    end
  endtask

  initial begin
    int c0, r0, n0, w0, v0, g, len;
    logic [15:0] base;
    rst = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_reg = 0; cmd_len = '0;
    wr_valid = 0; wr_data = '0; rd_ready = 1'b1; status_val = 16'h1234;
    f_cmd_valid = 0; f_cmd_write = 0; f_cmd_reg = 0; f_cmd_len = '0;
    f_wr_valid = 0; f_wr_data = '0; f_rd_ready = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_r_n", r_n, 1'b1);
    chk("rst_w_n", w_n, 1'b1);
    chk("rst_addr", hpi_addr, 2'd0);
    chk("rst_dout", dout, 16'h0);
    chk("rst_oe", oe, 1'b0);
    chk("rst_rd_data", rd_data, 16'h0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1'b1);

    // Single STATUS reads: fixed value, then a random one.
    for (int k = 0; k < 2; k++) begin
      if (k == 1) status_val = 16'($urandom);
      c0 = cs_low; r0 = rn_low; n0 = rd_q.size();
      send_cmd(1'b0, 2'd3, 0);
      @(negedge clk);
      chk("rd_first_cs", cs_n, 1'b0);
      chk("rd_addr", hpi_addr, 2'd3);
      chk("busy_ignores_cmd", cmd_ready, 1'b0);
      wait_idle("rd_idle", 1'b0);
      chk("rd_cs_cycles", cs_low - c0, S + ST + H);
      chk("rd_rn_cycles", rn_low - r0, ST);
      chk("rd_pulses", rd_q.size() - n0, 1);
      if (rd_q.size() > n0) chk("rd_status", rd_q[n0], status_val);
      chk("rd_data_reg", rd_data, status_val);
    end

    // ADDRESS=0x1000 then 4-word DATA write.
    w0 = wn_pulses; v0 = viol_oe_rn;
    set_ptr(16'h1000);
    wq = '{16'hA0, 16'hA1, 16'hA2, 16'hA3};
    write_burst(2'd0, 1'b0);
    chk("wr_pulses", wn_pulses - w0, 5);
    for (int i = 0; i < 4; i++) chk("wr_mem", mem[16'h1000 + i], 16'hA0 + i);

    // Gapped 4-word write at a random base, then read back with a 10-cycle stall on word 2.
    base = 16'($urandom_range(0, 16'hFFF0));
    set_ptr(base);
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back(16'($urandom));
    w0 = wn_pulses;
    write_burst(2'd0, 1'b1);
    chk("gap_pulses", wn_pulses - w0, 4);
    chk("gap_wait_cs_high", viol_wr_cs, 0);
    set_ptr(base);
    n0 = rd_q.size();
    send_cmd(1'b0, 2'd0, 3);
    g = 0;
    while (rd_q.size() < n0 + 1 && g < 200) begin @(negedge clk); g++; end
    rd_ready = 1'b0;
    g = 0;
    while (!rd_valid && g < 200) begin @(negedge clk); g++; end
    repeat (10) @(negedge clk);
    chk("stall_cs_n", cs_n, 1'b1);
    chk("stall_rd_valid", rd_valid, 1'b1);
    rd_ready = 1'b1;
    wait_idle("stall_idle", 1'b0);
    check_reads(n0, 4);
    chk("stall_cs_high", viol_rd_cs, 0);

    // Random bursts with random write gaps and random read backpressure.
    for (int k = 0; k < 3; k++) begin
      len = $urandom_range(1, 6);
      base = 16'($urandom_range(0, 16'hFFF0));
      set_ptr(base);
      wq.delete();
      for (int i = 0; i < len; i++) wq.push_back(16'($urandom));
      write_burst(2'd0, 1'($urandom_range(0, 1)));
      set_ptr(base);
      n0 = rd_q.size();
      send_cmd(1'b0, 2'd0, len - 1);
      wait_idle("rnd_idle", 1'b1);
      check_reads(n0, len);
    end
    chk("oe_vs_rn", viol_oe_rn, 0);
    chk("rd_cs_high_all", viol_rd_cs, 0);

    // Reset during the third strobe of an 8-word write.
    w0 = wn_pulses;
    wr_valid = 1'b1; wr_data = 16'($urandom);
    send_cmd(1'b1, 2'd0, 7);
    g = 0;
    while (wn_pulses < w0 + 3 && g < 500) begin @(negedge clk); wr_data = 16'($urandom); g++; end
    chk("rst_mid_in_strobe", w_n, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_mid_cs_n", cs_n, 1'b1);
    chk("rst_mid_w_n", w_n, 1'b1);
    chk("rst_mid_oe", oe, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    wr_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_wr_ready", wr_ready, 1'b0);
    chk("rst_mid_rd_valid", rd_valid, 1'b0);
    rst = 1'b0;
    status_val = 16'($urandom);
    n0 = rd_q.size();
    send_cmd(1'b0, 2'd3, 0);
    wait_idle("post_rst_idle", 1'b0);
    chk("post_rst_pulses", rd_q.size() - n0, 1);
    if (rd_q.size() > n0) chk("post_rst_status", rd_q[n0], status_val);

    // Fast timing instance: 256-word write burst.
    for (int i = 0; i < 256; i++) f_exp[i] = 16'($urandom);
    @(negedge clk);
    f_cmd_valid = 1'b1; f_cmd_write = 1'b1; f_cmd_reg = 2'd0; f_cmd_len = 8'd255;
    f_wr_valid = 1'b1; f_wr_data = f_exp[0];
    chk("fast_cmd_ready", f_cmd_ready, 1'b1);
    @(posedge clk); #1;
    f_cmd_valid = 1'b0;
    for (int i = 0; i < 256; i++) begin
      f_wr_data = f_exp[i];
      g = 0;
      do begin @(negedge clk); g++; end while (!f_wr_ready && g < 50);
      @(posedge clk); #1;
    end
    f_wr_valid = 1'b0;
    g = 0;
    while (f_busy && g < 100) begin @(negedge clk); g++; end
    chk("fast_idle", f_busy, 1'b0);
    chk("fast_strobes", f_falls, 256);
    chk("fast_period", f_period_bad, 0);
    chk("fast_data", f_data_bad, 0);
    repeat (12) @(negedge clk);
    chk("fast_no_wrap", f_falls, 256);
    chk("fast_ready_again", f_cmd_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
